// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the multiplier / accumulator pipeline:
// field widths, special encodings, the accumulator state enum and unpack helpers.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MAN_W   = FRAC_W + 1;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    OUT   = 3'd4
  } state_t;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
  endfunction

  // Denormals and zeros carry no hidden bit and are flushed to a zero mantissa.
  function automatic logic [MAN_W-1:0] unpack_man(input logic [31:0] v);
    return (v[30:23] != 8'd0) ? {1'b1, v[22:0]} : 24'd0;
  endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input reports 24.
module fp_lzc24 (
  input  logic [23:0] data,
  output logic [4:0]  count
);

  // Highest set bit wins because it is visited last.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      count = data[i] ? 5'(23 - i) : count;
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Multi-cycle FP32 packet accumulator: align, add, normalize per element,
// then hold the truncated packet sum until the consumer takes it.
module fp_accumulator
  import fp32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t             state_r, state_nx;
  logic               accept_s;
  logic               in_ready_r, out_valid_r;
  logic [31:0]        out_data_r;
  logic [CNT_W-1:0]   out_count_r;

  logic [31:0]        acc_r, op_r;
  logic               last_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [MAN_W-1:0]   m_big_r, m_small_r;
  logic [EXP_W-1:0]   exp_r;
  logic               s_big_r, s_small_r;
  logic               special_r;
  logic [31:0]        special_val_r;
  logic [MAN_W:0]     sum_r;
  logic               sign_r;

  logic [EXP_W-1:0]   big_exp_s, small_exp_s, diff_s;
  logic [MAN_W-1:0]   big_man_s, small_man_s, small_sh_s;
  logic               big_sign_s, small_sign_s;
  logic               sp_s;
  logic [31:0]        sp_val_s;
  logic [MAN_W:0]     add_sum_s;
  logic               add_sign_s;
  logic [4:0]         lzc_s;
  logic signed [9:0]  norm_exp_s;
  logic [MAN_W-1:0]   norm_man_s;
  logic [31:0]        norm_res_s;

  assign accept_s  = in_valid & in_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_count = out_count_r;

  // Next-state logic for the per-element sequence.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    state_nx = accept_s ? ALIGN : IDLE;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = last_r ? OUT : IDLE;
      OUT:     state_nx = out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end

  // Operand ordering, barrel alignment and special-value detection.
  always_comb begin
    if (op_r[30:23] > acc_r[30:23]) begin
      big_exp_s    = op_r[30:23];
      big_man_s    = unpack_man(op_r);
      big_sign_s   = op_r[31];
      small_exp_s  = acc_r[30:23];
      small_man_s  = unpack_man(acc_r);
      small_sign_s = acc_r[31];
    end else begin
      big_exp_s    = acc_r[30:23];
      big_man_s    = unpack_man(acc_r);
      big_sign_s   = acc_r[31];
      small_exp_s  = op_r[30:23];
      small_man_s  = unpack_man(op_r);
      small_sign_s = op_r[31];
    end
    diff_s = big_exp_s - small_exp_s;
    if (diff_s >= 8'd24) begin
      small_sh_s = 24'd0;
    end else begin
      small_sh_s = small_man_s >> diff_s;
    end

    if (is_nan(op_r) || is_nan(acc_r)) begin
      sp_s     = 1'b1;
      sp_val_s = QNAN;
    end else if (is_inf(op_r) && is_inf(acc_r)) begin
      sp_s     = 1'b1;
      sp_val_s = (op_r[31] != acc_r[31]) ? QNAN : acc_r;
    end else if (is_inf(acc_r)) begin
      sp_s     = 1'b1;
      sp_val_s = acc_r;
    end else if (is_inf(op_r)) begin
      sp_s     = 1'b1;
      sp_val_s = op_r;
    end else begin
      sp_s     = 1'b0;
      sp_val_s = 32'h0000_0000;
    end
  end

  // Signed-magnitude add: result takes the sign of the larger magnitude.
  always_comb begin
    if (s_big_r == s_small_r) begin
      add_sum_s  = {1'b0, m_big_r} + {1'b0, m_small_r};
      add_sign_s = s_big_r;
    end else if (m_big_r >= m_small_r) begin
      add_sum_s  = {1'b0, m_big_r} - {1'b0, m_small_r};
      add_sign_s = s_big_r;
    end else begin
      add_sum_s  = {1'b0, m_small_r} - {1'b0, m_big_r};
      add_sign_s = s_small_r;
    end
  end

  fp_lzc24 u_lzc (
    .data  (sum_r[MAN_W-1:0]),
    .count (lzc_s)
  );

  // Normalization, overflow to infinity and underflow flush.
  always_comb begin
    if (sum_r[MAN_W]) begin
      norm_man_s = sum_r[MAN_W:1];
      norm_exp_s = $signed({2'b00, exp_r}) + 10'sd1;
    end else begin
      norm_man_s = sum_r[MAN_W-1:0] << lzc_s;
      norm_exp_s = $signed({2'b00, exp_r}) - $signed({5'b00000, lzc_s});
    end

    if (special_r) begin
      norm_res_s = special_val_r;
    end else if (!norm_man_s[MAN_W-1]) begin
      norm_res_s = 32'h0000_0000;
    end else if (norm_exp_s >= 10'(EXP_MAX)) begin
      norm_res_s = {sign_r, 8'hFF, 23'd0};
    end else if (norm_exp_s <= 10'sd0) begin
      norm_res_s = 32'h0000_0000;
    end else begin
      norm_res_s = {sign_r, norm_exp_s[7:0], norm_man_s[FRAC_W-1:0]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath registers, each stage loading only in its own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r         <= 32'h0000_0000;
      op_r          <= 32'h0000_0000;
      last_r        <= 1'b0;
      cnt_r         <= '0;
      m_big_r       <= 24'd0;
      m_small_r     <= 24'd0;
      exp_r         <= 8'd0;
      s_big_r       <= 1'b0;
      s_small_r     <= 1'b0;
      special_r     <= 1'b0;
      special_val_r <= 32'h0000_0000;
      sum_r         <= 25'd0;
      sign_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r   <= in_data;
            last_r <= in_last;
            cnt_r  <= (cnt_r == '1) ? cnt_r : cnt_r + CNT_W'(1);
          end
        end
        ALIGN: begin
          m_big_r       <= big_man_s;
          m_small_r     <= small_sh_s;
          exp_r         <= big_exp_s;
          s_big_r       <= big_sign_s;
          s_small_r     <= small_sign_s;
          special_r     <= sp_s;
          special_val_r <= sp_val_s;
        end
        ADD: begin
          sum_r  <= add_sum_s;
          sign_r <= add_sign_s;
        end
        NORM: begin
          acc_r <= norm_res_s;
        end
        OUT: begin
          if (out_ready) begin
            acc_r <= 32'h0000_0000;
            cnt_r <= '0;
          end
        end
        default: begin
          acc_r <= 32'h0000_0000;
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      out_count_r <= '0;
    end else begin
      in_ready_r  <= (state_nx == IDLE);
      out_valid_r <= (state_nx == OUT);
      if ((state_r == NORM) && last_r) begin
        out_data_r  <= norm_res_s;
        out_count_r <= cnt_r;
      end else if ((state_r == OUT) && out_ready) begin
        out_data_r  <= 32'h0000_0000;
        out_count_r <= '0;
      end else begin
        out_data_r  <= out_data_r;
        out_count_r <= out_count_r;
      end
    end
  end

endmodule
